// File: rtl/switch_debounce.sv
// -----------------------------------------------------------------------------
// switch_debounce
//
// Synchronizes and debounces the slide-switch pins before they reach the
// switches_export input of the processor system. Each channel accepts a new
// level only after it has held for STABLE_TICKS consecutive prescaler ticks.
// A sticky per-bit change flag records every accepted toggle until firmware
// clears it through the clr_valid/clr_mask handshake.
//
// Parameters:
//   N_SW          number of switch channels
//   CLK_HZ        clock frequency in Hz
//   TICK_HZ       debounce tick rate; P = CLK_HZ/TICK_HZ must be an integer >= 2
//   STABLE_TICKS  ticks a new level must hold before acceptance (>= 2)
//
// Ports:
//   clk_clk        system clock
//   reset_reset_n  asynchronous active-low reset
//   sw_raw         asynchronous switch pins
//   sw_out         debounced level (drives switches_export)
//   sw_changed     sticky flag per bit: sw_out bit changed since last clear
//   change_irq     OR of sw_changed
//   clr_valid      clear strobe, sampled every clock edge
//   clr_mask       bits of sw_changed to clear when clr_valid is 1
//   tick           one-cycle prescaler pulse (debug)
// -----------------------------------------------------------------------------
module switch_debounce #(
   parameter int unsigned N_SW         = 10,
   parameter int unsigned CLK_HZ       = 50000000,
   parameter int unsigned TICK_HZ      = 1000,
   parameter int unsigned STABLE_TICKS = 10
) (
   input  logic            clk_clk,
   input  logic            reset_reset_n,
   input  logic [N_SW-1:0] sw_raw,
   output logic [N_SW-1:0] sw_out,
   output logic [N_SW-1:0] sw_changed,
   output logic            change_irq,
   input  logic            clr_valid,
   input  logic [N_SW-1:0] clr_mask,
   output logic            tick
);

   // ---------------------------------------------------------------------------
   // Derived constants
   // ---------------------------------------------------------------------------
   localparam int unsigned P  = CLK_HZ / TICK_HZ;
   localparam int unsigned PW = $clog2(P);
   localparam int unsigned CW = $clog2(STABLE_TICKS);

   localparam logic [PW-1:0] P_LAST = PW'(P - 1);
   localparam logic [CW-1:0] C_LAST = CW'(STABLE_TICKS - 1);

   // Control FSM encoding
   localparam logic [0:0] ST_INIT = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   // Number of INIT cycles minus one; the load happens on the last INIT cycle.
   localparam logic [1:0] INIT_LAST = 2'd2;

   // ---------------------------------------------------------------------------
   // Two-flop synchronizer per channel
   // ---------------------------------------------------------------------------
   logic [N_SW-1:0] sync_meta;
   logic [N_SW-1:0] sync;

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         sync_meta <= '0;
         sync      <= '0;
      end else begin
         sync_meta <= sw_raw;
         sync      <= sync_meta;
      end
   end

   // ---------------------------------------------------------------------------
   // Prescaler: free-running from reset release, independent of the FSM
   // ---------------------------------------------------------------------------
   logic [PW-1:0] pre_cnt_q;
   logic [PW-1:0] pre_cnt_d;

   assign tick = (pre_cnt_q == P_LAST);

   always_comb begin
      pre_cnt_d = pre_cnt_q + PW'(1);
      if (tick) begin
         pre_cnt_d = '0;
      end
   end

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         pre_cnt_q <= '0;
      end else begin
         pre_cnt_q <= pre_cnt_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Control FSM: INIT waits for the synchronizer to fill, then loads sw_out
   // directly from the pins so that power-up raises no change flags.
   // ---------------------------------------------------------------------------
   logic [0:0] state_q;
   logic [0:0] state_d;
   logic [1:0] init_cnt_q;
   logic [1:0] init_cnt_d;
   logic       load;
   logic       run;

   always_comb begin
      state_d    = state_q;
      init_cnt_d = init_cnt_q;
      load       = 1'b0;
      case (state_q)
         ST_INIT: begin
            if (init_cnt_q == INIT_LAST) begin
               load       = 1'b1;
               init_cnt_d = '0;
               state_d    = ST_RUN;
            end else begin
               init_cnt_d = init_cnt_q + 2'd1;
            end
         end
         ST_RUN: begin
            state_d = ST_RUN;
         end
         default: begin
            state_d = ST_INIT;
         end
      endcase
   end

   assign run = (state_q == ST_RUN);

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         state_q    <= ST_INIT;
         init_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         init_cnt_q <= init_cnt_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Output and flag registers (declared ahead of the channels that read them)
   // ---------------------------------------------------------------------------
   logic [N_SW-1:0] sw_out_q;
   logic [N_SW-1:0] sw_out_d;
   logic [N_SW-1:0] sw_chg_q;
   logic [N_SW-1:0] sw_chg_d;
   logic [N_SW-1:0] upd;

   // ---------------------------------------------------------------------------
   // Per-channel stability counters. A channel counter only advances on ticks
   // while sync disagrees with sw_out; any cycle of agreement (a bounce back to
   // the old level) restarts it, whether or not a tick is present.
   // ---------------------------------------------------------------------------
   for (genvar i = 0; i < N_SW; i++) begin : g_ch
      logic [CW-1:0] cnt_q;
      logic [CW-1:0] cnt_d;
      logic          ch_upd;

      always_comb begin
         cnt_d  = cnt_q;
         ch_upd = 1'b0;
         if (load) begin
            cnt_d = '0;
         end else if (run) begin
            if (sync[i] == sw_out_q[i]) begin
               cnt_d = '0;
            end else if (tick && (cnt_q == C_LAST)) begin
               cnt_d  = '0;
               ch_upd = 1'b1;
            end else if (tick) begin
               cnt_d = cnt_q + CW'(1);
            end
         end
      end

      always_ff @(posedge clk_clk or negedge reset_reset_n) begin
         if (!reset_reset_n) begin
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_d;
         end
      end

      assign upd[i] = ch_upd;
   end

   // ---------------------------------------------------------------------------
   // sw_out / sw_changed next state. An update only fires when sync differs
   // from sw_out, so flipping the bit is the same as copying sync. A set in the
   // same cycle as a clear of the same bit wins, so no toggle is lost.
   // ---------------------------------------------------------------------------
   always_comb begin
      sw_out_d = sw_out_q ^ upd;
      if (load) begin
         sw_out_d = sync;
      end

      sw_chg_d = sw_chg_q;
      if (clr_valid) begin
         sw_chg_d = sw_chg_q & ~clr_mask;
      end
      sw_chg_d = sw_chg_d | upd;
   end

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         sw_out_q <= '0;
         sw_chg_q <= '0;
      end else begin
         sw_out_q <= sw_out_d;
         sw_chg_q <= sw_chg_d;
      end
   end

   assign sw_out     = sw_out_q;
   assign sw_changed = sw_chg_q;
   assign change_irq = |sw_chg_q;

endmodule

// File: tb/tb_switch_debounce.sv
// -----------------------------------------------------------------------------
// tb_switch_debounce
//
// Scoreboard bench for switch_debounce with P = 10 and STABLE_TICKS = 3.
// Stimulus pushes expected output events (value plus allowed cycle window)
// into a queue; the monitor pops an entry each time the outputs change and
// compares. Snapshot entries compare the current outputs at the next sample.
// -----------------------------------------------------------------------------
module tb_switch_debounce;

   localparam int N_SW = 10;
   localparam int P    = 10;
   localparam int ST   = 3;

   logic            clk = 1'b0;
   logic            reset_reset_n;
   logic [N_SW-1:0] sw_raw;
   logic [N_SW-1:0] sw_out;
   logic [N_SW-1:0] sw_changed;
   logic            change_irq;
   logic            clr_valid;
   logic [N_SW-1:0] clr_mask;
   logic            tick;

   switch_debounce #(
      .N_SW         (N_SW),
      .CLK_HZ       (1000),
      .TICK_HZ      (100),
      .STABLE_TICKS (ST)
   ) dut (
      .clk_clk       (clk),
      .reset_reset_n (reset_reset_n),
      .sw_raw        (sw_raw),
      .sw_out        (sw_out),
      .sw_changed    (sw_changed),
      .change_irq    (change_irq),
      .clr_valid     (clr_valid),
      .clr_mask      (clr_mask),
      .tick          (tick)
   );

   always #5 clk = ~clk;

   // Interval index: number of rising edges seen so far.
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      string           name;
      bit              snap;
      bit              use_tk;
      logic [N_SW-1:0] out;
      logic [N_SW-1:0] chg;
      int              lo;
      int              hi;
   } exp_t;

   exp_t sb_q[$];
   int   tick_q[$];
   int   checks = 0;
   int   errors = 0;
   bit   done   = 1'b0;
   logic probe  = 1'b0;
   int   c0     = 0;

   // Observed cycle of the debounced update when the pin changes in interval cp:
   // sync differs from interval cp+2, and the update lands on the edge closing
   // the STABLE_TICKS-th tick interval from then.
   function automatic int upd_cycle(input int cp);
      int k;
      k = cp + 2;
      while (((k - c0) % P) != P - 1) k++;
      return k + (ST - 1) * P + 1;
   endfunction

   task automatic expect_change(input string name, input logic [N_SW-1:0] out,
                                input logic [N_SW-1:0] chg, input int lo, input int hi);
      exp_t e;
      e.name = name; e.snap = 1'b0; e.use_tk = 1'b0;
      e.out = out; e.chg = chg; e.lo = lo; e.hi = hi;
      sb_q.push_back(e);
   endtask

   task automatic expect_snap(input string name, input logic [N_SW-1:0] out,
                              input logic [N_SW-1:0] chg, input bit use_tk);
      exp_t e;
      e.name = name; e.snap = 1'b1; e.use_tk = use_tk;
      e.out = out; e.chg = chg; e.lo = 0; e.hi = 0;
      sb_q.push_back(e);
   endtask

   task automatic next_slot();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_until(input int target);
      while (cyc < target) next_slot();
   endtask

   task automatic wait_drain(input string what);
      int n;
      n = 0;
      while (sb_q.size() != 0) begin
         next_slot();
         n++;
         if (n > 200) begin
            $display("FAIL %s: scoreboard still holds %0d entries, required 0", what, sb_q.size());
            $fatal(1, "scoreboard stalled");
         end
      end
   endtask

   // ---------------------------------------------------------------------------
   // Monitor
   // ---------------------------------------------------------------------------
   initial begin
      logic [N_SW-1:0] p_out;
      logic [N_SW-1:0] p_chg;
      logic            p_irq;
      exp_t            e;
      int              t;
      p_out = '0;
      p_chg = '0;
      p_irq = 1'b0;
      forever begin
         @(negedge clk or posedge probe);
         if (done) begin
            while (sb_q.size() != 0) begin
               e = sb_q.pop_front();
               checks++; errors++;
               $display("FAIL %s: event never seen, required sw_out=%h sw_changed=%h",
                        e.name, e.out, e.chg);
            end
            while (tick_q.size() != 0) begin
               t = tick_q.pop_front();
               checks++; errors++;
               $display("FAIL tick: no tick seen, required at cycle %0d", t);
            end
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
         end

         if (tick_q.size() != 0) begin
            if (tick === 1'b1) begin
               t = tick_q.pop_front();
               checks++;
               if (cyc != t) begin
                  errors++;
                  $display("FAIL tick: pulse at cycle %0d, required cycle %0d", cyc, t);
               end
            end else if (cyc > tick_q[0]) begin
               t = tick_q.pop_front();
               checks++; errors++;
               $display("FAIL tick: no pulse at cycle %0d, required one", t);
            end
         end

         if (sb_q.size() != 0 && sb_q[0].snap) begin
            e = sb_q.pop_front();
            checks++;
            if (sw_out !== e.out || sw_changed !== e.chg || change_irq !== (|e.chg)) begin
               errors++;
               $display("FAIL %s: sw_out=%h sw_changed=%h change_irq=%b, required %h %h %b",
                        e.name, sw_out, sw_changed, change_irq, e.out, e.chg, |e.chg);
            end
            if (e.use_tk) begin
               checks++;
               if (tick !== 1'b0) begin
                  errors++;
                  $display("FAIL %s_tick: tick=%b, required 0", e.name, tick);
               end
            end
         end else if (sw_out !== p_out || sw_changed !== p_chg || change_irq !== p_irq) begin
            if (sb_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected: cycle %0d sw_out=%h sw_changed=%h, required %h %h",
                        cyc, sw_out, sw_changed, p_out, p_chg);
            end else begin
               e = sb_q.pop_front();
               checks++;
               if (sw_out !== e.out || sw_changed !== e.chg || change_irq !== (|e.chg)) begin
                  errors++;
                  $display("FAIL %s: sw_out=%h sw_changed=%h change_irq=%b, required %h %h %b",
                           e.name, sw_out, sw_changed, change_irq, e.out, e.chg, |e.chg);
               end
               checks++;
               if (cyc < e.lo || cyc > e.hi) begin
                  errors++;
                  $display("FAIL %s_timing: event at cycle %0d, required cycle %0d..%0d",
                           e.name, cyc, e.lo, e.hi);
               end
            end
         end else if (sb_q.size() != 0 && cyc > sb_q[0].hi) begin
            e = sb_q.pop_front();
            checks++; errors++;
            $display("FAIL %s: no event by cycle %0d, required sw_out=%h sw_changed=%h",
                     e.name, cyc, e.out, e.chg);
         end

         p_out = sw_out;
         p_chg = sw_changed;
         p_irq = change_irq;
      end
   end

   // ---------------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------------
   initial begin
      int cp;
      int t;
      int k1;
      sw_raw        = 10'h2A5;
      clr_valid     = 1'b0;
      clr_mask      = '0;
      reset_reset_n = 1'b1;
      #1 reset_reset_n = 1'b0;
      expect_snap("reset_state", 10'h000, 10'h000, 1'b1);
      repeat (3) next_slot();

      // Power-up load from the pins, no flags, ticks every P cycles.
      reset_reset_n = 1'b1;
      c0 = cyc;
      expect_change("powerup_load", 10'h2A5, 10'h000, c0 + 3, c0 + 3);
      tick_q.push_back(c0 + 9);
      tick_q.push_back(c0 + 19);
      tick_q.push_back(c0 + 29);
      wait_drain("powerup_load");

      // Clean toggle of bit 0.
      next_slot();
      sw_raw[0] = 1'b0;
      cp = cyc;
      t  = upd_cycle(cp);
      expect_change("clean_toggle", 10'h2A4, 10'h001, t, t);
      wait_drain("clean_toggle");

      // Bounce on bit 3 every 5 cycles must never be accepted.
      for (int i = 0; i < 40; i++) begin
         sw_raw[3] = ~sw_raw[3];
         repeat (5) next_slot();
      end
      sw_raw[3] = 1'b1;
      cp = cyc;
      t  = upd_cycle(cp);
      expect_change("bounce_then_hold", 10'h2AC, 10'h009, t, t);
      wait_drain("bounce_then_hold");

      // Clear handshake, one bit at a time.
      clr_valid = 1'b1;
      clr_mask  = 10'h008;
      expect_change("clear_bit3", 10'h2AC, 10'h001, cyc + 1, cyc + 1);
      next_slot();
      clr_valid = 1'b0;
      clr_mask  = '0;
      wait_drain("clear_bit3");
      clr_valid = 1'b1;
      clr_mask  = 10'h001;
      expect_change("clear_bit0", 10'h2AC, 10'h000, cyc + 1, cyc + 1);
      next_slot();
      clr_valid = 1'b0;
      clr_mask  = '0;
      wait_drain("clear_bit0");

      // Clear strobe on the exact update edge: the set must win.
      sw_raw[0] = 1'b1;
      cp = cyc;
      t  = upd_cycle(cp);
      expect_change("set_beats_clear", 10'h2AD, 10'h001, t, t);
      wait_until(t - 1);
      clr_valid = 1'b1;
      clr_mask  = 10'h001;
      next_slot();
      clr_valid = 1'b0;
      clr_mask  = '0;
      wait_drain("set_beats_clear");
      clr_valid = 1'b1;
      clr_mask  = 10'h3FF;
      expect_change("clear_all", 10'h2AD, 10'h000, cyc + 1, cyc + 1);
      next_slot();
      clr_valid = 1'b0;
      clr_mask  = '0;
      wait_drain("clear_all");

      // All pins invert together.
      sw_raw = 10'h152;
      cp = cyc;
      t  = upd_cycle(cp);
      expect_change("all_flip", 10'h152, 10'h3FF, t, t);
      wait_drain("all_flip");

      // Reset while bit 0's counter sits at 2 (two ticks counted, third pending).
      sw_raw[0] = 1'b1;
      cp = cyc;
      t  = upd_cycle(cp);
      k1 = t - (ST - 1) * P - 1;
      wait_until(k1 + 15);
      reset_reset_n = 1'b0;
      expect_change("async_reset", 10'h000, 10'h000, cyc, cyc);
      expect_snap("reset_hold", 10'h000, 10'h000, 1'b1);
      #1 probe = 1'b1;
      #1 probe = 1'b0;
      repeat (3) next_slot();
      reset_reset_n = 1'b1;
      c0 = cyc;
      expect_change("reinit_load", 10'h153, 10'h000, c0 + 3, c0 + 3);
      tick_q.push_back(c0 + 9);
      wait_drain("reinit_load");
      repeat (40) next_slot();
      expect_snap("quiet_after_reinit", 10'h153, 10'h000, 1'b0);
      wait_drain("quiet_after_reinit");
      next_slot();
      done = 1'b1;
   end

endmodule
